// File: rtl/mem_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_loader_if
// Brief    : Stream, memory-port and status bundle for the memory loader.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W:0]   length;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] checksum;

    // Host / memory side
    modport master (
        output start, length, in_data, in_valid, mem_rdata,
        input  in_ready, mem_addr, mem_wdata, mem_we, busy, done, error, checksum
    );

    // Loader side
    modport slave (
        input  start, length, in_data, in_valid, mem_rdata,
        output in_ready, mem_addr, mem_wdata, mem_we, busy, done, error, checksum
    );
endinterface
`default_nettype wire

// File: rtl/mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Brief    : Streams a block of words into memory from address 0, then reads
//            it back and checks it against the running checksum.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] c_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] vsum_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic              hs_d;
    logic              len_ok_d;
    logic [DATA_W-1:0] vsum_d;

    assign hs_d     = in_ready_q & bus.in_valid;
    assign len_ok_d = (bus.length != '0) && (bus.length <= c_MAX_LEN);
    // The final read-back word must be part of the comparison, so compare the
    // sum including the current read rather than the registered one.
    assign vsum_d   = vsum_q + bus.mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            vsum_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (len_ok_d) begin
                            state_q    <= S_LOAD;
                            len_q      <= bus.length;
                            addr_q     <= '0;
                            count_q    <= '0;
                            sum_q      <= '0;
                            vsum_q     <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                            error_q    <= 1'b0;
                        end else begin
                            done_q  <= 1'b0;
                            error_q <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (hs_d) begin
                        sum_q   <= sum_q + bus.in_data;
                        addr_q  <= addr_q + ADDR_W'(1);
                        count_q <= count_q + (ADDR_W+1)'(1);
                        if (count_q == len_q - (ADDR_W+1)'(1)) begin
                            state_q    <= S_VERIFY;
                            addr_q     <= '0;
                            count_q    <= len_q;
                            in_ready_q <= 1'b0;
                        end
                    end
                end

                S_VERIFY: begin
                    vsum_q  <= vsum_d;
                    addr_q  <= addr_q + ADDR_W'(1);
                    count_q <= count_q - (ADDR_W+1)'(1);
                    if (count_q == (ADDR_W+1)'(1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (vsum_d == sum_q) begin
                            done_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Write strobe and data pass straight through so a word is written on the
    // same edge it is accepted; gating on in_ready_q drops it on async reset.
    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = hs_d;
    assign bus.mem_wdata = in_ready_q ? bus.in_data : '0;
    assign bus.mem_addr  = addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.checksum  = sum_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_loader
// Brief    : Scoreboard bench for mem_loader against a behavioural 256x8 RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_loader;
    localparam int DW = 8;
    localparam int AW = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic       dn;
        logic       er;
        logic [7:0] cs;
    } cmp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   corrupt = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    wr_t  wq[$];
    cmp_t cq[$];
    logic [7:0] ram [0:255];

    always #5 clk = ~clk;

    mem_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    end

    // Read-back fault injection: flip bit 0 of address 2 only while verifying
    assign bus.mem_rdata = ram[bus.mem_addr] ^
        ((corrupt && bus.busy && !bus.in_ready && bus.mem_addr == 8'd2) ? 8'h01 : 8'h00);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes on every write strobe, expected completion
    // on every rising done/error.
    logic pd = 1'b0;
    logic pe = 1'b0;
    always @(negedge clk) begin
        wr_t  w;
        cmp_t c;
        if (!rst_n) begin
            pd = 1'b0;
            pe = 1'b0;
        end else begin
            if (bus.mem_we) begin
                chk("we_needs_ready", {31'd0, bus.in_ready}, 32'd1);
                if (wq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", {24'd0, bus.mem_addr}, {24'd0, w.a});
                    chk("wr_data", {24'd0, bus.mem_wdata}, {24'd0, w.d});
                end
            end
            if ((bus.done && !pd) || (bus.error && !pe)) begin
                if (cq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_completion: done %0b error %0b, none expected",
                             bus.done, bus.error);
                end else begin
                    c = cq.pop_front();
                    chk("cmp_done",     {31'd0, bus.done},  {31'd0, c.dn});
                    chk("cmp_error",    {31'd0, bus.error}, {31'd0, c.er});
                    chk("cmp_checksum", {24'd0, bus.checksum}, {24'd0, c.cs});
                end
            end
            pd = bus.done;
            pe = bus.error;
        end
    end

    task automatic run(input int n, input logic [7:0] d[$], input int gap,
                       input bit poke, input cmp_t exp);
        int cyc;
        int vc;
        cq.push_back(exp);
        bus.length = n[8:0];
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                    cyc++;
                end
            end
            bus.in_data  = d[i];
            bus.in_valid = 1'b1;
            wq.push_back('{a: i[7:0], d: d[i]});
            if (poke && i == 1) begin
                bus.start  = 1'b1;
                bus.length = 9'd1;
            end
            @(posedge clk); #1;
            cyc++;
            bus.in_valid = 1'b0;
            bus.start    = 1'b0;
        end
        chk("verify_entry_addr",  {24'd0, bus.mem_addr}, 32'd0);
        chk("verify_ready_low",   {31'd0, bus.in_ready}, 32'd0);
        vc = 0;
        while (bus.busy && vc < 600) begin
            @(posedge clk); #1;
            vc++;
            cyc++;
        end
        chk("verify_cycles", vc, n);
        if (gap == 0) chk("done_latency", cyc, 2 * n + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        bus.start    = 1'b0;
        bus.length   = '0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;

        // Reset values
        #12;
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        chk("rst_mem_we",    {31'd0, bus.mem_we},   32'd0);
        chk("rst_mem_addr",  {24'd0, bus.mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        chk("rst_busy",      {31'd0, bus.busy},     32'd0);
        chk("rst_done",      {31'd0, bus.done},     32'd0);
        chk("rst_error",     {31'd0, bus.error},    32'd0);
        chk("rst_checksum",  {24'd0, bus.checksum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero length: error, no load
        cq.push_back('{dn: 1'b0, er: 1'b1, cs: 8'h00});
        bus.length = 9'd0;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("badlen_busy",  {31'd0, bus.busy},     32'd0);
        chk("badlen_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("badlen_error", {31'd0, bus.error},    32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Basic back-to-back load
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run(4, q, 0, 1'b0, '{dn: 1'b1, er: 1'b0, cs: 8'hAA});
        chk("mem0", {24'd0, ram[0]}, 32'h11);
        chk("mem1", {24'd0, ram[1]}, 32'h22);
        chk("mem2", {24'd0, ram[2]}, 32'h33);
        chk("mem3", {24'd0, ram[3]}, 32'h44);
        @(posedge clk); #1;

        // Start during LOAD must be ignored
        q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run(4, q, 0, 1'b1, '{dn: 1'b1, er: 1'b0, cs: 8'h0A});
        @(posedge clk); #1;

        // Read-back mismatch
        corrupt = 1'b1;
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run(4, q, 0, 1'b0, '{dn: 1'b0, er: 1'b1, cs: 8'hAA});
        corrupt = 1'b0;
        @(posedge clk); #1;

        // Gapped stream with checksum wrap
        q = '{8'hFF, 8'h01, 8'h80};
        run(3, q, 2, 1'b0, '{dn: 1'b1, er: 1'b0, cs: 8'h80});
        chk("gap_mem0", {24'd0, ram[0]}, 32'hFF);
        chk("gap_mem1", {24'd0, ram[1]}, 32'h01);
        chk("gap_mem2", {24'd0, ram[2]}, 32'h80);
        @(posedge clk); #1;

        // Full 256-word load, address wrap
        q = {};
        for (int i = 0; i < 256; i++) q.push_back(i[7:0]);
        run(256, q, 0, 1'b0, '{dn: 1'b1, er: 1'b0, cs: 8'h80});
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 256; i++) if (ram[i] !== i[7:0]) bad++;
            chk("full_mem_contents", bad, 0);
        end
        @(posedge clk); #1;

        // Async reset in the middle of a load
        bus.length = 9'd4;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_data  = (i == 0) ? 8'h11 : 8'h22;
            bus.in_valid = 1'b1;
            wq.push_back('{a: i[7:0], d: bus.in_data});
            @(posedge clk); #1;
        end
        bus.in_data  = 8'h33;
        bus.in_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_mem_we",   {31'd0, bus.mem_we},   32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("midrst_busy",     {31'd0, bus.busy},     32'd0);
        chk("midrst_done",     {31'd0, bus.done},     32'd0);
        chk("midrst_error",    {31'd0, bus.error},    32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_mem2_kept", {24'd0, ram[2]}, 32'h02);

        q = '{8'h5A};
        run(1, q, 0, 1'b0, '{dn: 1'b1, er: 1'b0, cs: 8'h5A});
        @(posedge clk); #1;

        // Oversize length: error, checksum keeps the last load
        cq.push_back('{dn: 1'b0, er: 1'b1, cs: 8'h5A});
        bus.length = 9'd257;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("oversize_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        chk("wq_drained", wq.size(), 0);
        chk("cq_drained", cq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Write-side counterpart to the 256x8 main memory: accepts a byte stream over a valid/ready handshake and writes it into consecutive memory locations from address 0.
- After loading, it reads the region back and checks it against a running checksum.
- It sits between a host/boot source and the memory's write and read ports, and drives the memory address bus while busy.

Parameters:
- DATA_W, 8, width of a memory word and stream byte.
- ADDR_W, 8, memory address width; maximum load length is 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- length  input  ADDR_W+1  number of words to load; legal range is 1..2**ADDR_W; sampled with start.
- in_data  input  DATA_W  stream word.
- in_valid  input  1  stream word present.
- in_ready  output  1  loader accepts in_data this cycle.
- mem_addr  output  ADDR_W  memory address, for both write and read-back.
- mem_wdata  output  DATA_W  memory write data.
- mem_we  output  1  memory write enable; the memory writes on the clk edge while high.
- mem_rdata  input  DATA_W  memory read data; combinational from mem_addr, valid in the same cycle.
- busy  output  1  high in LOAD and VERIFY.
- done  output  1  sticky; load verified OK.
- error  output  1  sticky; bad length or verify mismatch.
- checksum  output  DATA_W  mod-2**DATA_W sum of the words accepted in the current or most recent load.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE immediately.
  - Outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, checksum=0.
  - Internal counters and sums cleared.
- States: IDLE, LOAD, VERIFY. done and error are sticky flags, not states.
- IDLE:
  - in_ready=0, mem_we=0.
  - start with length in 1..2**ADDR_W -> LOAD next cycle.
    - addr=0, count=0, sum=0, vsum=0.
    - done and error cleared.
  - start with length=0 or length>2**ADDR_W -> stay IDLE, error=1 next cycle, done=0.
- LOAD:
  - in_ready=1 and busy=1.
  - mem_we = in_valid (combinational); mem_addr=addr; mem_wdata=in_data (combinational).
  - On a handshake (in_valid & in_ready) at a clock edge:
    - The word is written to mem[addr].
    - sum += in_data, wrapping mod 2**DATA_W.
    - addr+1 wraps mod 2**ADDR_W.
    - count+1.
  - in_valid low: no write; state, addr and sum hold. Gaps of any length are legal.
  - Handshake with count==length-1 -> VERIFY next cycle.
    - addr reset to 0.
    - in_ready deasserts in the VERIFY cycle.
  - The loader takes exactly length words; further words are not accepted because in_ready=0.
- VERIFY:
  - mem_we=0, in_ready=0, busy=1.
  - mem_addr=addr. Each cycle: vsum += mem_rdata, addr+1, count-1.
  - After length read cycles, compare at the final read edge:
    - vsum (including the final word) == sum -> IDLE, done=1.
    - otherwise -> IDLE, error=1.
  - VERIFY lasts exactly length cycles.
- checksum output = sum register. It holds after completion until the next accepted start.
- start outside IDLE is ignored, including start during LOAD or VERIFY.
- length=2**ADDR_W: addr wraps 255->0 on the last write; count is ADDR_W+1 bits, so there is no premature termination.
- Latency for length N with no gaps:
  - start edge -> LOAD.
  - N cycles of LOAD.
  - N cycles of VERIFY.
  - done visible N+N+1 cycles after the start edge.
- mem_addr in IDLE holds its last value; it is 0 only after reset.
- Reset mid-LOAD or mid-VERIFY:
  - Abort immediately and deassert mem_we asynchronously.
  - done=0 and error=0.
  - Memory contents already written are not rolled back.

Test Plan:
- Basic load: start, length=4, stream 0x11,0x22,0x33,0x44 back-to-back against a behavioural 256x8 RAM -> mem[0..3] hold those values, checksum=0xAA, done=1 at cycle 9 after start, error=0.
- Gapped stream: length=3, in_valid low for 2 cycles between words (0xFF,0x01,0x80) -> writes only on handshakes, checksum=0x80 (wrap), done=1.
- Full-size wrap: length=256, data=address value -> every mem[i]=i, mem_addr wraps to 0 entering VERIFY, checksum=0x80, VERIFY lasts 256 cycles, done=1.
- Verify mismatch: bench forces mem_rdata at address 2 to be XORed with 0x01 during VERIFY of the basic load -> error=1, done=0, checksum still 0xAA.
- Bad length and busy start:
  - start with length=0 -> error=1, state IDLE, no mem_we pulse.
  - start during LOAD -> ignored; count and addr unaffected.
- Reset mid-load: rst_n low after 2 of 4 words -> mem_we=0 and in_ready=0 immediately, all flags 0; a new start with length=1 then completes with done=1.
